// File: rtl/reflet_timer.sv
// Memory-mapped 16-bit compare timer with an 8-bit prescaler, a match flag and a level interrupt.
// Define REFLET_TIMER_SNAPSHOT_EN to latch CNT_HI on CNT_LO reads so 16-bit counter reads are coherent.
`timescale 1ns/10ps
module reflet_timer #(
    parameter int unsigned addr_size = 16,
    parameter int unsigned base_addr = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [addr_size-1:0] addr,
    input  logic                 write_en,
    input  logic [7:0]           data_in,
    output logic [7:0]           data_out,
    output logic                 interrupt
);

    typedef enum logic [2:0] {
        REG_CONFIG    = 3'd0,
        REG_PRESCALER = 3'd1,
        REG_CMP_LO    = 3'd2,
        REG_CMP_HI    = 3'd3,
        REG_STATUS    = 3'd4,
        REG_CNT_LO    = 3'd5,
        REG_CNT_HI    = 3'd6
    } reg_e;

    localparam logic [addr_size-1:0] BASE = addr_size'(base_addr);
    localparam logic [addr_size-1:0] SPAN = addr_size'(7);

    logic [addr_size-1:0] offset;
    logic                 hit;
    logic                 wr;
    reg_e                 sel;
    logic                 tick;
    logic                 cmp_match;
    logic                 hw_stop;

    logic [2:0]  config_q, config_d;
    logic [7:0]  prescaler_q, prescaler_d;
    logic [7:0]  cmp_lo_q, cmp_lo_d;
    logic [7:0]  cmp_hi_q, cmp_hi_d;
    logic        match_q, match_d;
    logic [7:0]  pre_cnt_q, pre_cnt_d;
    logic [15:0] count_q, count_d;
`ifdef REFLET_TIMER_SNAPSHOT_EN
    logic [7:0]  snap_q, snap_d;
`endif

    // Addresses below base wrap to large offsets, so one compare covers both bounds.
    always_comb begin
        offset = addr - BASE;
        hit    = enable && (offset < SPAN);
        wr     = hit && write_en;
        sel    = reg_e'(offset[2:0]);
    end

    always_comb begin
        tick      = config_q[0] && (pre_cnt_q == prescaler_q);
        cmp_match = tick && (count_q == {cmp_hi_q, cmp_lo_q});
        hw_stop   = cmp_match && !config_q[1];

        pre_cnt_d   = '0;
        count_d     = count_q;
        config_d    = config_q;
        prescaler_d = prescaler_q;
        cmp_lo_d    = cmp_lo_q;
        cmp_hi_d    = cmp_hi_q;
        match_d     = match_q;
`ifdef REFLET_TIMER_SNAPSHOT_EN
        snap_d      = snap_q;
        if (hit && (sel == REG_CNT_LO)) begin
            snap_d = count_q[15:8];
        end
`endif

        if (config_q[0] && !tick) begin
            pre_cnt_d = pre_cnt_q + 8'd1;
        end

        if (tick) begin
            if (!cmp_match) begin
                count_d = count_q + 16'd1;
            end else if (config_q[1]) begin
                count_d = '0;
            end
        end

        if (wr) begin
            case (sel)
                REG_CONFIG:    config_d    = data_in[2:0];
                REG_PRESCALER: prescaler_d = data_in;
                REG_CMP_LO:    cmp_lo_d    = data_in;
                REG_CMP_HI:    cmp_hi_d    = data_in;
                REG_STATUS: begin
                    if (!data_in[0]) begin
                        match_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end

        // Hardware events are applied last so they override a same-cycle bus write.
        if (cmp_match) begin
            match_d = 1'b1;
        end
        if (hw_stop) begin
            config_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            config_q    <= '0;
            prescaler_q <= '0;
            cmp_lo_q    <= '0;
            cmp_hi_q    <= '0;
            match_q     <= 1'b0;
            pre_cnt_q   <= '0;
            count_q     <= '0;
`ifdef REFLET_TIMER_SNAPSHOT_EN
            snap_q      <= '0;
`endif
        end else begin
            config_q    <= config_d;
            prescaler_q <= prescaler_d;
            cmp_lo_q    <= cmp_lo_d;
            cmp_hi_q    <= cmp_hi_d;
            match_q     <= match_d;
            pre_cnt_q   <= pre_cnt_d;
            count_q     <= count_d;
`ifdef REFLET_TIMER_SNAPSHOT_EN
            snap_q      <= snap_d;
`endif
        end
    end

    always_comb begin
        data_out = '0;
        if (hit) begin
            case (sel)
                REG_CONFIG:    data_out = {5'b0, config_q};
                REG_PRESCALER: data_out = prescaler_q;
                REG_CMP_LO:    data_out = cmp_lo_q;
                REG_CMP_HI:    data_out = cmp_hi_q;
                REG_STATUS:    data_out = {7'b0, match_q};
                REG_CNT_LO:    data_out = count_q[7:0];
`ifdef REFLET_TIMER_SNAPSHOT_EN
                REG_CNT_HI:    data_out = snap_q;
`else
                REG_CNT_HI:    data_out = count_q[15:8];
`endif
                default:       data_out = '0;
            endcase
        end
    end

    assign interrupt = match_q & config_q[2];

endmodule

// File: tb/tb_reflet_timer.sv
// Self-checking bench for reflet_timer: directed scenarios plus randomized bus traffic against a cycle model.
`timescale 1ns/10ps
module tb_reflet_timer;

    localparam logic [15:0] BASE = 16'h0040;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] addr = '0;
    logic        write_en = 1'b0;
    logic [7:0]  data_in = '0;
    logic [7:0]  data_out;
    logic        interrupt;

    int checks = 0;
    int errors = 0;

    logic [7:0] rd, ex;

    // Model: register contents plus the cycle position inside the current prescale period.
    logic [2:0]  m_cfg;
    logic [7:0]  m_psc;
    logic [15:0] m_cmp;
    logic        m_match;
    logic [7:0]  m_phase;
    logic [15:0] m_cnt;
`ifdef REFLET_TIMER_SNAPSHOT_EN
    logic [7:0]  m_snap;
`endif

    reflet_timer #(.addr_size(16), .base_addr(16'h0040)) dut (
        .clk(clk), .reset(reset), .enable(enable), .addr(addr),
        .write_en(write_en), .data_in(data_in), .data_out(data_out), .interrupt(interrupt)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        m_cfg = '0; m_psc = '0; m_cmp = '0; m_match = 1'b0; m_phase = '0; m_cnt = '0;
`ifdef REFLET_TIMER_SNAPSHOT_EN
        m_snap = '0;
`endif
    endtask

    function automatic logic [7:0] model_read(input logic en, input logic [15:0] a);
        logic [15:0] off;
        if (!en || a < BASE || a > BASE + 16'd6) return 8'h00;
        off = a - BASE;
        case (off)
            16'd0: return {5'b0, m_cfg};
            16'd1: return m_psc;
            16'd2: return m_cmp[7:0];
            16'd3: return m_cmp[15:8];
            16'd4: return {7'b0, m_match};
            16'd5: return m_cnt[7:0];
`ifdef REFLET_TIMER_SNAPSHOT_EN
            default: return m_snap;
`else
            default: return m_cnt[15:8];
`endif
        endcase
    endfunction

    function automatic bit model_match_next();
        return m_cfg[0] && (m_phase == m_psc) && (m_cnt == m_cmp);
    endfunction

    task automatic model_step(input logic en, input logic we, input logic [15:0] a, input logic [7:0] d);
        bit ticked, hit, stop;
        ticked = 0; hit = 0; stop = 0;
`ifdef REFLET_TIMER_SNAPSHOT_EN
        if (en && a == BASE + 16'd5) m_snap = m_cnt[15:8];
`endif
        if (m_cfg[0]) begin
            if (m_phase == m_psc) begin ticked = 1; m_phase = 0; end
            else m_phase = m_phase + 8'd1;
        end else m_phase = 0;
        if (ticked) begin
            if (m_cnt == m_cmp) begin
                hit = 1;
                if (m_cfg[1]) m_cnt = 0; else stop = 1;
            end else m_cnt = m_cnt + 16'd1;
        end
        if (en && we && a >= BASE && a <= BASE + 16'd6) begin
            case (a - BASE)
                16'd0: m_cfg = d[2:0];
                16'd1: m_psc = d;
                16'd2: m_cmp[7:0] = d;
                16'd3: m_cmp[15:8] = d;
                16'd4: if (!d[0]) m_match = 1'b0;
                default: ;
            endcase
        end
        if (hit) m_match = 1'b1;
        if (stop) m_cfg[0] = 1'b0;
    endtask

    // One bus cycle starting at a falling edge: drive, sample the read, clock, advance the model.
    task automatic bus_cycle(input logic en, input logic we, input logic [15:0] a, input logic [7:0] d);
        enable = en; write_en = we; addr = a; data_in = d;
        #1;
        rd = data_out;
        ex = model_read(en, a);
        @(posedge clk);
        model_step(en, we, a, d);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        enable = 1'b0; write_en = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        model_clear();
        #2;
        for (int unsigned i = 0; i < 7; i++) begin
            enable = 1'b1; addr = BASE + 16'(i);
            #1;
            checks++;
            if (data_out !== 8'h00) begin
                errors++;
                $display("FAIL reset_read off=%0d got=%02h exp=00", i, data_out);
            end
        end
        checks++;
        if (interrupt !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", interrupt); end
        @(negedge clk);
        reset = 1'b1;
        repeat (10) bus_cycle(1'b0, 1'b0, 16'h0, 8'h00);
        bus_cycle(1'b1, 1'b0, BASE + 16'd5, 8'h00);
        checks++;
        if (rd !== 8'h00) begin errors++; $display("FAIL idle_count got=%02h exp=00", rd); end
    endtask

    task automatic test_periodic();
        int n;
        do_reset();
        bus_cycle(1, 1, BASE + 16'd1, 8'd3);
        bus_cycle(1, 1, BASE + 16'd2, 8'd2);
        bus_cycle(1, 1, BASE + 16'd3, 8'd0);
        bus_cycle(1, 1, BASE + 16'd0, 8'h07);
        n = 0;
        while (n < 40) begin
            bus_cycle(1, 0, BASE + 16'd5, 8'h00);
            n++;
            checks++;
            if (rd !== ex) begin errors++; $display("FAIL periodic_count cyc=%0d got=%02h exp=%02h", n, rd, ex); end
            if (interrupt === 1'b1) break;
        end
        checks++;
        if (n != 12) begin errors++; $display("FAIL periodic_match_cycle got=%0d exp=12", n); end
        bus_cycle(1, 0, BASE + 16'd5, 8'h00);
        checks++;
        if (rd !== 8'h00) begin errors++; $display("FAIL periodic_reload got=%02h exp=00", rd); end
        bus_cycle(1, 0, BASE + 16'd4, 8'h00);
        checks++;
        if (rd !== 8'h01 || interrupt !== 1'b1) begin
            errors++; $display("FAIL periodic_status got=%02h irq=%b exp=01 irq=1", rd, interrupt);
        end
    endtask

    task automatic test_oneshot();
        do_reset();
        bus_cycle(1, 1, BASE + 16'd1, 8'd0);
        bus_cycle(1, 1, BASE + 16'd2, 8'd5);
        bus_cycle(1, 1, BASE + 16'd3, 8'd0);
        bus_cycle(1, 1, BASE + 16'd0, 8'h01);
        for (int unsigned i = 0; i < 20; i++) begin
            bus_cycle(1, 0, BASE + 16'd5, 8'h00);
            checks++;
            if (rd !== ex || interrupt !== 1'b0) begin
                errors++; $display("FAIL oneshot_run cyc=%0d got=%02h irq=%b exp=%02h irq=0", i, rd, interrupt, ex);
            end
        end
        bus_cycle(1, 0, BASE + 16'd5, 8'h00);
        checks++;
        if (rd !== 8'h05) begin errors++; $display("FAIL oneshot_count got=%02h exp=05", rd); end
        bus_cycle(1, 0, BASE + 16'd0, 8'h00);
        checks++;
        if (rd !== 8'h00) begin errors++; $display("FAIL oneshot_config got=%02h exp=00", rd); end
        bus_cycle(1, 0, BASE + 16'd4, 8'h00);
        checks++;
        if (rd !== 8'h01) begin errors++; $display("FAIL oneshot_status got=%02h exp=01", rd); end
    endtask

    task automatic test_status_race();
        int n;
        do_reset();
        bus_cycle(1, 1, BASE + 16'd1, 8'd0);
        bus_cycle(1, 1, BASE + 16'd2, 8'd3);
        bus_cycle(1, 1, BASE + 16'd0, 8'h03);
        n = 0;
        while (!model_match_next() && n < 30) begin
            bus_cycle(0, 0, 16'h0, 8'h00);
            n++;
        end
        checks++;
        if (n >= 30) begin errors++; $display("FAIL race_timeout waited=%0d limit=30", n); end
        bus_cycle(1, 1, BASE + 16'd4, 8'h00);
        bus_cycle(1, 0, BASE + 16'd4, 8'h00);
        checks++;
        if (rd !== 8'h01) begin errors++; $display("FAIL race_set_wins got=%02h exp=01", rd); end
        bus_cycle(1, 1, BASE + 16'd4, 8'h00);
        bus_cycle(1, 0, BASE + 16'd4, 8'h00);
        checks++;
        if (rd !== 8'h00) begin errors++; $display("FAIL race_clear got=%02h exp=00", rd); end
    endtask

    task automatic test_snapshot();
        int n;
        do_reset();
        bus_cycle(1, 1, BASE + 16'd1, 8'd0);
        bus_cycle(1, 1, BASE + 16'd2, 8'hFF);
        bus_cycle(1, 1, BASE + 16'd3, 8'hFF);
        bus_cycle(1, 1, BASE + 16'd0, 8'h01);
        n = 0;
        while (m_cnt != 16'h00FF && n < 400) begin
            bus_cycle(0, 0, 16'h0, 8'h00);
            n++;
        end
        checks++;
        if (n >= 400) begin errors++; $display("FAIL snap_timeout waited=%0d limit=400", n); end
        bus_cycle(1, 0, BASE + 16'd5, 8'h00);
        checks++;
        if (rd !== 8'hFF) begin errors++; $display("FAIL snap_lo got=%02h exp=ff", rd); end
        bus_cycle(1, 0, BASE + 16'd6, 8'h00);
        checks++;
`ifdef REFLET_TIMER_SNAPSHOT_EN
        if (rd !== 8'h00) begin errors++; $display("FAIL snap_hi got=%02h exp=00", rd); end
`else
        if (rd !== 8'h01) begin errors++; $display("FAIL snap_hi got=%02h exp=01", rd); end
`endif
    endtask

    task automatic test_random();
        logic [15:0] a;
        logic [7:0]  d;
        int unsigned off, r;
        do_reset();
        for (int unsigned i = 0; i < 800; i++) begin
            r   = $urandom_range(0, 9);
            off = $urandom_range(0, 8);
            a   = BASE + 16'(off) - 16'd1;
            case (off)
                2: d = 8'($urandom_range(0, 3));
                3: d = 8'($urandom_range(0, 31));
                4: d = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'h00;
                default: d = 8'($urandom_range(0, 255));
            endcase
            if (r < 3) bus_cycle(1, 1, a, d);
            else if (r < 8) bus_cycle(1, 0, a, d);
            else bus_cycle(0, r[0], a, d);
            checks++;
            if (rd !== ex) begin errors++; $display("FAIL rand_read i=%0d addr=%04h got=%02h exp=%02h", i, a, rd, ex); end
            checks++;
            if (interrupt !== (m_match & m_cfg[2])) begin
                errors++; $display("FAIL rand_irq i=%0d got=%b exp=%b", i, interrupt, m_match & m_cfg[2]);
            end
        end
    endtask

    task automatic test_async_reset();
        int n;
        do_reset();
        bus_cycle(1, 1, BASE + 16'd1, 8'd0);
        bus_cycle(1, 1, BASE + 16'd2, 8'd2);
        bus_cycle(1, 1, BASE + 16'd0, 8'h07);
        n = 0;
        while (interrupt !== 1'b1 && n < 50) begin
            bus_cycle(0, 0, 16'h0, 8'h00);
            n++;
        end
        checks++;
        if (n >= 50) begin errors++; $display("FAIL areset_setup waited=%0d limit=50", n); end
        bus_cycle(0, 0, 16'h0, 8'h00);
        // Falling edge now; the next rising edge is 5 ns away.
        #2 reset = 1'b0;
        for (int unsigned i = 0; i < 9; i++) begin
            enable = 1'b1; addr = BASE + 16'(i) - 16'd1;
            #0.2;
            checks++;
            if (data_out !== 8'h00) begin
                errors++; $display("FAIL areset_read addr=%04h got=%02h exp=00", addr, data_out);
            end
        end
        checks++;
        if (interrupt !== 1'b0) begin errors++; $display("FAIL areset_irq got=%b exp=0", interrupt); end
        model_clear();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        bus_cycle(1, 0, BASE + 16'd0, 8'h00);
        checks++;
        if (rd !== 8'h00) begin errors++; $display("FAIL areset_idle got=%02h exp=00", rd); end
    endtask

    task automatic test_wrap();
        int n;
        do_reset();
        bus_cycle(1, 1, BASE + 16'd1, 8'd0);
        bus_cycle(1, 1, BASE + 16'd2, 8'h00);
        bus_cycle(1, 1, BASE + 16'd3, 8'h01);
        bus_cycle(1, 1, BASE + 16'd0, 8'h01);
        n = 0;
        while (m_cnt != 16'd15 && n < 100) begin
            bus_cycle(0, 0, 16'h0, 8'h00);
            n++;
        end
        bus_cycle(1, 1, BASE + 16'd0, 8'h00);
        bus_cycle(1, 0, BASE + 16'd5, 8'h00);
        checks++;
        if (rd !== 8'h10) begin errors++; $display("FAIL wrap_start got=%02h exp=10", rd); end
        bus_cycle(1, 1, BASE + 16'd3, 8'h00);
        bus_cycle(1, 1, BASE + 16'd0, 8'h05);
        n = 0;
        while (interrupt !== 1'b1 && n < 70000) begin
            bus_cycle(0, 0, 16'h0, 8'h00);
            n++;
        end
        checks++;
        if (n != 65521) begin errors++; $display("FAIL wrap_match_cycle got=%0d exp=65521", n); end
        bus_cycle(1, 0, BASE + 16'd5, 8'h00);
        checks++;
        if (rd !== 8'h00) begin errors++; $display("FAIL wrap_cnt_lo got=%02h exp=00", rd); end
        bus_cycle(1, 0, BASE + 16'd6, 8'h00);
        checks++;
        if (rd !== 8'h00) begin errors++; $display("FAIL wrap_cnt_hi got=%02h exp=00", rd); end
        bus_cycle(1, 0, BASE + 16'd0, 8'h00);
        checks++;
        if (rd !== 8'h04) begin errors++; $display("FAIL wrap_config got=%02h exp=04", rd); end
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_oneshot();
        test_status_race();
        test_snapshot();
        test_random();
        test_async_reset();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reflet_timer.md
REFLET_TIMER -- requirements
Module: reflet_timer

Interface
REQ-001 Parameter addr_size, default 16, SHALL set the width of the system-bus address.
REQ-002 Parameter base_addr, default 0, SHALL set the bus address of register offset 0; the block SHALL occupy offsets 0..6.
REQ-003 Port clk, input, 1: SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: SHALL be an asynchronous, active-low reset.
REQ-005 Port enable, input, 1: SHALL qualify bus reads and writes.
REQ-006 Port addr, input, addr_size: SHALL be the byte address of the bus access.
REQ-007 Port write_en, input, 1: SHALL be the write strobe.
REQ-008 Port data_in, input, 8: SHALL be the write data.
REQ-009 Port data_out, output, 8: SHALL be the read data.
REQ-010 Port interrupt, output, 1: SHALL be the level interrupt request.

Function
REQ-011 Register map, offset from base_addr: 0 CONFIG (bit0 run, bit1 auto_reload, bit2 irq_en, bits7:3 read 0); 1 PRESCALER; 2 CMP_LO; 3 CMP_HI; 4 STATUS (bit0 match, bits7:1 read 0); 5 CNT_LO, read-only; 6 CNT_HI, read-only.
REQ-012 A write (enable, write_en, addr matching a writable offset) SHALL update that register on the next rising edge; writes to offsets 5, 6 or unmapped addresses SHALL be ignored.
REQ-013 data_out SHALL be combinational: the addressed register when enable is high and addr is in 0..6; 0x00 otherwise.
REQ-014 While run=0, the 8-bit prescale counter SHALL be held at 0 and the 16-bit count SHALL hold its value.
REQ-015 While run=1, the prescale counter SHALL increment each cycle; when it equals PRESCALER it SHALL return to 0 and assert a one-cycle tick. One tick therefore occurs every PRESCALER+1 cycles.
REQ-016 On a tick with count != {CMP_HI,CMP_LO}, count SHALL increment modulo 2^16, wrapping 0xFFFF to 0x0000.
REQ-017 On a tick with count == {CMP_HI,CMP_LO}, STATUS.match SHALL be set. If auto_reload=1, count SHALL become 0. If auto_reload=0, count SHALL hold and CONFIG.run SHALL be cleared by the hardware.
REQ-018 A compare value of 0 SHALL match on the first tick after count reaches 0.
REQ-019 Writing the compare value below the current count SHALL NOT force a match; the count SHALL wrap and match on a later pass.
REQ-020 A bus write to STATUS with bit0=0 SHALL clear match; a write with bit0=1 SHALL have no effect.
REQ-021 When a hardware match and a STATUS write occur in the same cycle, the set SHALL win.
REQ-022 When the hardware clears run (REQ-017) and a CONFIG write occurs in the same cycle, the hardware clear of bit0 SHALL win; the other bits SHALL take the written value.
REQ-023 A CONFIG write that changes run from 0 to 1 SHALL start the prescale counter from 0; count SHALL be unchanged.
REQ-024 interrupt SHALL equal STATUS.match AND CONFIG.irq_en, and SHALL be registered-state driven, with no combinational path from bus inputs.

Reset
REQ-025 While reset=0, all of the following SHALL be 0 immediately, independent of clk: CONFIG, PRESCALER, CMP_LO, CMP_HI, STATUS, prescale counter, count, snapshot, and interrupt.
REQ-026 After reset deasserts, the block SHALL remain idle until a write sets run.
REQ-027 Reset asserted mid-count SHALL abandon the count and any pending match.

Configuration
REQ-028 Macro REFLET_TIMER_SNAPSHOT_EN SHALL control coherent 16-bit counter reads.
REQ-029 With REFLET_TIMER_SNAPSHOT_EN defined, a read of CNT_LO (enable, addr=offset 5) SHALL latch count[15:8] into an 8-bit snapshot on that clock edge, and CNT_HI reads SHALL return the snapshot.
REQ-030 Without REFLET_TIMER_SNAPSHOT_EN, CNT_HI SHALL return live count[15:8] and no snapshot register SHALL exist.

Verification
REQ-031 Setup: PRESCALER=3, CMP=0x0002, CONFIG=0x07. Required: a tick every 4 cycles; match and interrupt set on the 3rd tick; count=0 on the following cycle.
REQ-032 Setup: CONFIG=0x01 (no reload), PRESCALER=0, CMP=0x0005. Required: count stops at 5, CONFIG reads 0x00, STATUS reads 0x01, interrupt stays 0.
REQ-033 Stimulus: a STATUS write of 0x00 on the same cycle as a match. Required: STATUS stays 0x01; a STATUS write of 0x00 on a later cycle clears it to 0x00.
REQ-034 Setup: CMP=0x0000 while count=0x0010, PRESCALER=0. Required: count wraps through 0xFFFF to 0x0000, then match fires on the next tick.
REQ-035 Setup: count=0x00FF, PRESCALER=0. Stimulus: read CNT_LO, then CNT_HI one cycle later. Required with the macro: 0xFF then 0x00. Required without the macro: 0xFF then 0x01.
REQ-036 Stimulus: assert reset asynchronously between clock edges during counting. Required: all registers read 0x00 and interrupt=0 before the next clk edge; an access to an unmapped address returns data_out=0x00.
